// File: rtl/tile_spawner.sv
// Places one "2"/"4" tile on the first empty cell, scanning forward from a random start cell.
// Optional macro SPAWN_FOUR_EN enables "4" tiles; without it only "2" tiles spawn.
module tile_spawner #(
    parameter int unsigned N_CELLS     = 16,
    parameter int unsigned EXP_W       = 4,
    parameter int unsigned FOUR_THRESH = 2,
    localparam int unsigned IDX_W      = $clog2(N_CELLS)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_spawn_req,
    input  logic [N_CELLS*EXP_W-1:0] i_board_in,
    input  logic [IDX_W-1:0]         i_rand_pos,
    input  logic [3:0]               i_rand_val,
    output logic                     o_busy,
    output logic                     o_spawn_done,
    output logic [IDX_W-1:0]         o_spawn_idx,
    output logic [EXP_W-1:0]         o_spawn_exp,
    output logic [N_CELLS*EXP_W-1:0] o_board_out,
    output logic                     o_board_full
);

    typedef enum logic {StIdle, StScan} state_t;

    state_t                     r_state;
    logic [N_CELLS*EXP_W-1:0]   r_board;
    logic [IDX_W-1:0]           r_ptr;
    logic [IDX_W-1:0]           r_cnt;
    logic [EXP_W-1:0]           r_exp_sel;
    logic                       r_busy;
    logic                       r_spawn_done;
    logic                       r_board_full;
    logic [IDX_W-1:0]           r_spawn_idx;
    logic [EXP_W-1:0]           r_spawn_exp;
    logic [N_CELLS*EXP_W-1:0]   r_board_out;

    logic [EXP_W-1:0]           w_cell;
    logic [EXP_W-1:0]           w_exp_sel_new;
    logic [N_CELLS*EXP_W-1:0]   w_board_ins;

`ifdef SPAWN_FOUR_EN
    assign w_exp_sel_new = (32'(i_rand_val) < FOUR_THRESH) ? EXP_W'(2) : EXP_W'(1);
`else
    logic w_unused_rand_val;
    assign w_unused_rand_val = ^i_rand_val;
    assign w_exp_sel_new     = EXP_W'(1);
`endif

    assign w_cell = r_board[r_ptr*EXP_W +: EXP_W];

    // Snapshot with the selected tile dropped into the current scan cell
    always_comb begin
        w_board_ins                        = r_board;
        w_board_ins[r_ptr*EXP_W +: EXP_W]  = r_exp_sel;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_board      <= '0;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_exp_sel    <= '0;
            r_busy       <= 1'b0;
            r_spawn_done <= 1'b0;
            r_board_full <= 1'b0;
            r_spawn_idx  <= '0;
            r_spawn_exp  <= '0;
            r_board_out  <= '0;
        end else begin
            r_spawn_done <= 1'b0;
            r_board_full <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_spawn_req) begin
                        r_board   <= i_board_in;
                        r_ptr     <= i_rand_pos;
                        r_cnt     <= '0;
                        r_exp_sel <= w_exp_sel_new;
                        r_state   <= StScan;
                        r_busy    <= 1'b1;
                    end
                end
                StScan: begin
                    if (w_cell == '0) begin
                        r_board_out  <= w_board_ins;
                        r_spawn_idx  <= r_ptr;
                        r_spawn_exp  <= r_exp_sel;
                        r_spawn_done <= 1'b1;
                        r_state      <= StIdle;
                        r_busy       <= 1'b0;
                    end else if (r_cnt == IDX_W'(N_CELLS - 1)) begin
                        r_board_full <= 1'b1;
                        r_state      <= StIdle;
                        r_busy       <= 1'b0;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_spawn_done = r_spawn_done;
    assign o_spawn_idx  = r_spawn_idx;
    assign o_spawn_exp  = r_spawn_exp;
    assign o_board_out  = r_board_out;
    assign o_board_full = r_board_full;

endmodule

// File: tb/tb_tile_spawner.sv
// Self-checking bench for tile_spawner: directed scenarios plus randomized boards checked
// against a first-empty-cell search model.
module tb_tile_spawner;

    localparam int NC = 16;
    localparam int EW = 4;
    localparam logic [63:0] ALL_ONES_BOARD = 64'h1111_1111_1111_1111;

    logic        clk = 1'b0;
    logic        reset;
    logic        spawn_req;
    logic [63:0] board_in;
    logic [3:0]  rand_pos;
    logic [3:0]  rand_val;
    logic        busy;
    logic        spawn_done;
    logic [3:0]  spawn_idx;
    logic [3:0]  spawn_exp;
    logic [63:0] board_out;
    logic        board_full;

    int n_cmp = 0;
    int n_err = 0;

    // Expected held outputs
    logic [63:0] exp_bo;
    logic [3:0]  exp_idx;
    logic [3:0]  exp_e;

    tile_spawner dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_spawn_req  (spawn_req),
        .i_board_in   (board_in),
        .i_rand_pos   (rand_pos),
        .i_rand_val   (rand_val),
        .o_busy       (busy),
        .o_spawn_done (spawn_done),
        .o_spawn_idx  (spawn_idx),
        .o_spawn_exp  (spawn_exp),
        .o_board_out  (board_out),
        .o_board_full (board_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: first empty cell at forward offset j from pos, with wrap-around
    function automatic void model(input logic [63:0] b, input logic [3:0] pos,
                                  input logic [3:0] val, output bit full,
                                  output logic [3:0] idx, output int lat,
                                  output logic [3:0] e);
        full = 1'b1;
        idx  = '0;
        lat  = NC;
        for (int j = 0; j < NC; j++) begin
            int c;
            c = (int'(pos) + j) % NC;
            if (full && b[c*EW +: EW] == 4'd0) begin
                full = 1'b0;
                idx  = 4'(c);
                lat  = 1 + j;
            end
        end
`ifdef SPAWN_FOUR_EN
        e = (val < 4'd2) ? 4'd2 : 4'd1;
`else
        e = 4'd1;
`endif
    endfunction

    task automatic run_spawn(input string tag, input logic [63:0] b, input logic [3:0] pos,
                             input logic [3:0] val, input bit hammer, input bit scramble);
        bit          m_full;
        logic [3:0]  m_idx;
        logic [3:0]  m_e;
        int          m_lat;
        int          seen;
        bit          got_done;
        bit          got_full;
        model(b, pos, val, m_full, m_idx, m_lat, m_e);
        seen     = 0;
        got_done = 1'b0;
        got_full = 1'b0;
        @(negedge clk);
        board_in  = b;
        rand_pos  = pos;
        rand_val  = val;
        spawn_req = 1'b1;
        @(posedge clk);
        #1;
        spawn_req = 1'b0;
        check({tag, ":busy_rise"}, 64'(busy), 64'd1);
        for (int k = 1; k <= 20 && seen == 0; k++) begin
            @(negedge clk);
            spawn_req = hammer;
            if (scramble) begin
                board_in = 64'h9999_9999_9999_9999;
                rand_pos = 4'($urandom);
                rand_val = 4'($urandom);
            end
            @(posedge clk);
            #1;
            if (spawn_done || board_full) begin
                seen     = k;
                got_done = spawn_done;
                got_full = board_full;
            end
        end
        spawn_req = 1'b0;
        check({tag, ":latency"}, 64'(seen), 64'(m_lat));
        check({tag, ":done"}, 64'(got_done), 64'(!m_full));
        check({tag, ":full"}, 64'(got_full), 64'(m_full));
        check({tag, ":busy_fall"}, 64'(busy), 64'd0);
        if (!m_full) begin
            exp_bo                   = b;
            exp_bo[m_idx*EW +: EW]   = m_e;
            exp_idx                  = m_idx;
            exp_e                    = m_e;
        end
        check({tag, ":idx"}, 64'(spawn_idx), 64'(exp_idx));
        check({tag, ":exp"}, 64'(spawn_exp), 64'(exp_e));
        check({tag, ":board_out"}, board_out, exp_bo);
        @(posedge clk);
        #1;
        check({tag, ":pulse_end"}, 64'({spawn_done, board_full}), 64'd0);
        check({tag, ":idle_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [63:0] rb;
        int          dens;
        int          stray;

        reset     = 1'b1;
        spawn_req = 1'b0;
        board_in  = '0;
        rand_pos  = '0;
        rand_val  = '0;
        exp_bo    = '0;
        exp_idx   = '0;
        exp_e     = '0;
        #12;
        check("reset:flags", 64'({busy, spawn_done, board_full}), 64'd0);
        check("reset:idx_exp", 64'({spawn_idx, spawn_exp}), 64'd0);
        check("reset:board_out", board_out, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_spawn("empty_pos5", 64'd0, 4'd5, 4'd7, 1'b0, 1'b0);
        run_spawn("wrap_14", 64'h3300_0000_0000_0003, 4'd14, 4'd0, 1'b0, 1'b0);
        run_spawn("all_full", 64'h5555_5555_5555_5555, 4'd9, 4'd1, 1'b0, 1'b0);
        run_spawn("only8_hammer", ALL_ONES_BOARD & ~(64'hF << 32), 4'd9, 4'd3, 1'b1, 1'b0);
        run_spawn("snapshot3", ALL_ONES_BOARD & ~(64'hF << 12), 4'd3, 4'd1, 1'b0, 1'b1);

        // Reset during the third scan cycle aborts without any pulse
        @(negedge clk);
        board_in  = ALL_ONES_BOARD & ~(64'hF << 48);
        rand_pos  = 4'd0;
        spawn_req = 1'b1;
        @(posedge clk);
        #1;
        spawn_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset:busy", 64'(busy), 64'd0);
        check("midreset:pulses", 64'({spawn_done, board_full}), 64'd0);
        check("midreset:board_out", board_out, 64'd0);
        check("midreset:idx_exp", 64'({spawn_idx, spawn_exp}), 64'd0);
        exp_bo  = '0;
        exp_idx = '0;
        exp_e   = '0;
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (spawn_done || board_full || busy) stray++;
        end
        check("midreset:no_activity", 64'(stray), 64'd0);
        run_spawn("after_reset", ALL_ONES_BOARD & ~(64'hF << 48), 4'd0, 4'd9, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            dens = $urandom_range(0, 8);
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 15) < dens) rb[c*EW +: EW] = 4'd0;
                else rb[c*EW +: EW] = 4'($urandom_range(1, 11));
            end
            run_spawn($sformatf("rand%0d", t), rb, 4'($urandom), 4'($urandom),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
